ball_motion: RTL and testbench
==============================

// Module: ball_motion
//
// PURPOSE
// Per-ball kinematics stage directly downstream of the collision/hit logic.
// Consumes the replacement velocity and collision flag for one ball, plus cue
// strikes and hole hits. Applies friction and integrates position once per
// video frame. Drives the ball's top-left pixel position and current velocity
// back to the drawing and collision stages. One instance per ball (white, red).
//
// PARAMETERS
// FRAC        4    fractional bits of position/velocity (1/16 pixel)
// INIT_X      100  reset/respawn top-left X, integer pixels
// INIT_Y      200  reset/respawn top-left Y, integer pixels
// MIN_X/MIN_Y 0    lowest legal top-left X/Y, pixels
// MAX_X       608  highest legal top-left X, pixels
// MAX_Y       448  highest legal top-left Y, pixels
// FRICTION    1    magnitude subtracted from each velocity axis per frame, vel units
// MAX_SPEED   255  saturation magnitude per axis, vel units
//
// PORTS
// clk              in  1   system clock
// resetN           in  1   synchronous reset, active-high (1 = reset)
// startOfFrame     in  1   one-cycle pulse per frame; update tick
// collisionOccurred in 1   from hit controller: replace velocity this frame
// velXIn, velYIn   in  11s replacement velocity, valid while collisionOccurred=1
// hitValid         in  1   cue strike request
// hitVelX, hitVelY in  11s strike velocity, valid with hitValid
// hitReady         out 1   1 iff state==IDLE; strike accepted on hitValid&hitReady
// holeDR           in  1   ball pixel overlaps any hole this cycle
// respawn          in  1   pulse: leave SUNK, return to INIT position
// topLeftX/Y       out 11s integer pixel position (internal pos >>> FRAC)
// velX, velY       out 11s current velocity, vel units
// moving           out 1   1 iff state==MOVING
// sunk             out 1   1 iff state==SUNK
//
// BEHAVIOUR
// - Internal pos regs: signed 11+FRAC bits. Reset: pos=INIT<<FRAC, vel=0, IDLE.
//   Reset outputs: topLeft=INIT_X/INIT_Y, vel=0, moving=0, sunk=0, hitReady=1.
// - FSM IDLE -> MOVING: accepted strike or latched collision with nonzero vel.
//   MOVING -> IDLE: both vel axes 0 after a frame update.
//   any -> SUNK: holeDR=1, outside SUNK. SUNK -> IDLE: respawn=1 (pos=INIT, vel=0).
// - Event latching between ticks: collisionOccurred sets colPend and captures
//   velXIn/velYIn (last capture wins). Strike in IDLE sets hitPend and captures
//   hitVel; hitReady drops next cycle (FSM goes MOVING at capture).
// - Priority in the same cycle: resetN > holeDR > respawn > collision > hit.
//   holeDR clears all pending events. In SUNK, collision/hit/tick are ignored.
// - On startOfFrame (not SUNK):
//   v0 = colPend ? colVel : hitPend ? hitVel : vel.
//   v1 = saturate(v0, +/-MAX_SPEED).
//   v2 = |v1|<=FRICTION ? 0 : v1 - sign(v1)*FRICTION.
//   vel <= v2; pos <= clamp(pos + v2, MIN<<FRAC, MAX<<FRAC).
//   Clear both pend flags.
// - Clamp hit on an axis zeroes that velocity axis; border reflection
//   belongs upstream.
// - Event coincident with startOfFrame: applied in that same update.
// - Latency: tick at cycle T -> new pos/vel/moving visible at T+1 (registered).
// - All arithmetic signed; intermediate sums one bit wider; no wrap-around.
//
// TESTING
// 1 reset: resetN=1 two cycles -> topLeft=(100,200), vel=0, hitReady=1, moving=0.
// 2 strike hitVel=(32,0), 3 ticks -> vel 31,30,29 (in units); topLeftX 101,103,105.
// 3 collision velIn=(-20,5) mid-frame while MOVING -> next tick vel=(-19,4).
// 4 saturation/clamp: hitVel=(400,0) -> vel 254 after 1st tick; at MAX_X pos
//   holds 608 and velX=0.
// 5 holeDR with tick same cycle -> sunk=1, vel=0; subsequent hits ignored.
//   respawn -> IDLE at (100,200).
// 6 hitValid while MOVING -> ignored; |vel|=1 -> 0 after tick; moving=0 next cycle.

Source files
------------

// File: rtl/ball_motion.sv
// Per-ball kinematics: latches collision/strike events between frame ticks,
// applies saturation and friction to the velocity, and integrates a
// fixed-point position that is clamped to the legal play area.
module ball_motion #(
    parameter int FRAC      = 4,
    parameter int INIT_X    = 100,
    parameter int INIT_Y    = 200,
    parameter int MIN_X     = 0,
    parameter int MIN_Y     = 0,
    parameter int MAX_X     = 608,
    parameter int MAX_Y     = 448,
    parameter int FRICTION  = 1,
    parameter int MAX_SPEED = 255
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               collisionOccurred,
    input  logic signed [10:0] velXIn,
    input  logic signed [10:0] velYIn,
    input  logic               hitValid,
    input  logic signed [10:0] hitVelX,
    input  logic signed [10:0] hitVelY,
    output logic               hitReady,
    input  logic               holeDR,
    input  logic               respawn,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic signed [10:0] velX,
    output logic signed [10:0] velY,
    output logic               moving,
    output logic               sunk
);

    localparam int PW = 11 + FRAC;

    localparam logic signed [10:0] MAX_V  = 11'(MAX_SPEED);
    localparam logic signed [10:0] FRIC_V = 11'(FRICTION);

    localparam logic signed [PW-1:0] INIT_PX = PW'(INIT_X * (2 ** FRAC));
    localparam logic signed [PW-1:0] INIT_PY = PW'(INIT_Y * (2 ** FRAC));

    localparam logic signed [PW:0] LO_X = (PW + 1)'(MIN_X * (2 ** FRAC));
    localparam logic signed [PW:0] LO_Y = (PW + 1)'(MIN_Y * (2 ** FRAC));
    localparam logic signed [PW:0] HI_X = (PW + 1)'(MAX_X * (2 ** FRAC));
    localparam logic signed [PW:0] HI_Y = (PW + 1)'(MAX_Y * (2 ** FRAC));

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        SUNK   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic signed [PW-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic signed [10:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d;
    logic               col_pend_q, col_pend_d, hit_pend_q, hit_pend_d;
    logic signed [10:0] col_vx_q, col_vx_d, col_vy_q, col_vy_d;
    logic signed [10:0] hit_vx_q, hit_vx_d, hit_vy_q, hit_vy_d;

    logic               hit_accept;
    logic signed [10:0] v0_x, v0_y, v2_x, v2_y;
    logic [PW:0]        step_x, step_y;

    // Saturate to +/-MAX_SPEED, then bleed FRICTION toward zero without overshoot.
    function automatic logic signed [10:0] sat_fric(input logic signed [10:0] v);
        logic signed [10:0] s;
        if (v > MAX_V)        s = MAX_V;
        else if (v < -MAX_V)  s = -MAX_V;
        else                  s = v;
        if (s <= FRIC_V && s >= -FRIC_V) sat_fric = 11'sd0;
        else if (s > 11'sd0)             sat_fric = s - FRIC_V;
        else                             sat_fric = s + FRIC_V;
    endfunction

    // Returns {clamped, new_pos}; the sum is one bit wider so it cannot wrap.
    function automatic logic [PW:0] integrate(input logic signed [PW-1:0] p,
                                             input logic signed [10:0]   v,
                                             input logic signed [PW:0]   lo,
                                             input logic signed [PW:0]   hi);
        logic signed [PW:0] sum;
        sum = (PW + 1)'(p) + (PW + 1)'(v);
        if (sum < lo)      integrate = {1'b1, lo[PW-1:0]};
        else if (sum > hi) integrate = {1'b1, hi[PW-1:0]};
        else               integrate = {1'b0, sum[PW-1:0]};
    endfunction

    // Next-state logic: hole > respawn > collision > strike, then the frame update.
    always_comb begin
        state_d    = state_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        vel_x_d    = vel_x_q;
        vel_y_d    = vel_y_q;
        col_pend_d = col_pend_q;
        col_vx_d   = col_vx_q;
        col_vy_d   = col_vy_q;
        hit_pend_d = hit_pend_q;
        hit_vx_d   = hit_vx_q;
        hit_vy_d   = hit_vy_q;
        v0_x       = vel_x_q;
        v0_y       = vel_y_q;
        v2_x       = 11'sd0;
        v2_y       = 11'sd0;
        step_x     = '0;
        step_y     = '0;
        hit_accept = hitValid && (state_q == IDLE) && !collisionOccurred;

        if (state_q != SUNK && holeDR) begin
            state_d    = SUNK;
            vel_x_d    = 11'sd0;
            vel_y_d    = 11'sd0;
            col_pend_d = 1'b0;
            hit_pend_d = 1'b0;
        end else if (state_q == SUNK) begin
            if (respawn) begin
                state_d    = IDLE;
                pos_x_d    = INIT_PX;
                pos_y_d    = INIT_PY;
                vel_x_d    = 11'sd0;
                vel_y_d    = 11'sd0;
                col_pend_d = 1'b0;
                hit_pend_d = 1'b0;
            end
        end else begin
            if (collisionOccurred) begin
                col_pend_d = 1'b1;
                col_vx_d   = velXIn;
                col_vy_d   = velYIn;
                if (state_q == IDLE && (velXIn != 11'sd0 || velYIn != 11'sd0))
                    state_d = MOVING;
            end
            if (hit_accept) begin
                hit_pend_d = 1'b1;
                hit_vx_d   = hitVelX;
                hit_vy_d   = hitVelY;
                state_d    = MOVING;
            end
            if (startOfFrame) begin
                if (col_pend_d) begin
                    v0_x = col_vx_d;
                    v0_y = col_vy_d;
                end else if (hit_pend_d) begin
                    v0_x = hit_vx_d;
                    v0_y = hit_vy_d;
                end
                v2_x    = sat_fric(v0_x);
                v2_y    = sat_fric(v0_y);
                step_x  = integrate(pos_x_q, v2_x, LO_X, HI_X);
                step_y  = integrate(pos_y_q, v2_y, LO_Y, HI_Y);
                pos_x_d = step_x[PW-1:0];
                pos_y_d = step_y[PW-1:0];
                vel_x_d = step_x[PW] ? 11'sd0 : v2_x;
                vel_y_d = step_y[PW] ? 11'sd0 : v2_y;
                col_pend_d = 1'b0;
                hit_pend_d = 1'b0;
                state_d = (vel_x_d != 11'sd0 || vel_y_d != 11'sd0) ? MOVING : IDLE;
            end
        end
    end

    // State and datapath registers with synchronous reset to the spawn point.
    always_ff @(posedge clk) begin
        if (resetN) begin
            state_q    <= IDLE;
            pos_x_q    <= INIT_PX;
            pos_y_q    <= INIT_PY;
            vel_x_q    <= 11'sd0;
            vel_y_q    <= 11'sd0;
            col_pend_q <= 1'b0;
            col_vx_q   <= 11'sd0;
            col_vy_q   <= 11'sd0;
            hit_pend_q <= 1'b0;
            hit_vx_q   <= 11'sd0;
            hit_vy_q   <= 11'sd0;
        end else begin
            state_q    <= state_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            vel_x_q    <= vel_x_d;
            vel_y_q    <= vel_y_d;
            col_pend_q <= col_pend_d;
            col_vx_q   <= col_vx_d;
            col_vy_q   <= col_vy_d;
            hit_pend_q <= hit_pend_d;
            hit_vx_q   <= hit_vx_d;
            hit_vy_q   <= hit_vy_d;
        end
    end

    assign topLeftX = pos_x_q[PW-1:FRAC];
    assign topLeftY = pos_y_q[PW-1:FRAC];
    assign velX     = vel_x_q;
    assign velY     = vel_y_q;
    assign moving   = (state_q == MOVING);
    assign sunk     = (state_q == SUNK);
    assign hitReady = (state_q == IDLE);

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: a vector table for strike, collision and
// friction behaviour, plus hand sequences for sinking and wall clamping.
module tb_ball_motion;

    logic               clk = 1'b0;
    logic               resetN, startOfFrame, collisionOccurred;
    logic signed [10:0] velXIn, velYIn, hitVelX, hitVelY;
    logic               hitValid, hitReady, holeDR, respawn;
    logic signed [10:0] topLeftX, topLeftY, velX, velY;
    logic               moving, sunk;

    int checks = 0;
    int errors = 0;

    ball_motion dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .collisionOccurred(collisionOccurred), .velXIn(velXIn), .velYIn(velYIn),
        .hitValid(hitValid), .hitVelX(hitVelX), .hitVelY(hitVelY),
        .hitReady(hitReady), .holeDR(holeDR), .respawn(respawn),
        .topLeftX(topLeftX), .topLeftY(topLeftY), .velX(velX), .velY(velY),
        .moving(moving), .sunk(sunk)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               rst, sof, col, hit, hole, resp;
        logic signed [10:0] vxi, vyi, hvx, hvy;
        logic signed [10:0] ex, ey, evx, evy;
        logic               emov, esunk, erdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, sof, col, input int vxi, vyi,
                                input logic hit, input int hvx, hvy,
                                input int ex, ey, evx, evy, input logic emov, erdy);
        vec_t v;
        v.rst = rst; v.sof = sof; v.col = col; v.hit = hit; v.hole = 1'b0; v.resp = 1'b0;
        v.vxi = 11'(vxi); v.vyi = 11'(vyi); v.hvx = 11'(hvx); v.hvy = 11'(hvy);
        v.ex = 11'(ex); v.ey = 11'(ey); v.evx = 11'(evx); v.evy = 11'(evy);
        v.emov = emov; v.esunk = 1'b0; v.erdy = erdy;
        return v;
    endfunction

    // Drive one cycle of inputs on the falling edge, then sample 1 after the rise.
    task automatic applyStimulus(input logic rst, sof, col, input logic signed [10:0] vxi, vyi,
                                 input logic hit, input logic signed [10:0] hvx, hvy,
                                 input logic hole, resp);
        @(negedge clk);
        resetN = rst; startOfFrame = sof; collisionOccurred = col;
        velXIn = vxi; velYIn = vyi; hitValid = hit; hitVelX = hvx; hitVelY = hvy;
        holeDR = hole; respawn = resp;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int ex, ey, evx, evy,
                               input logic emov, esunk, erdy);
        checks++;
        if (topLeftX !== 11'(ex) || topLeftY !== 11'(ey) || velX !== 11'(evx) ||
            velY !== 11'(evy) || moving !== emov || sunk !== esunk || hitReady !== erdy) begin
            errors++;
            $display("[TB] FAIL %s: got pos=(%0d,%0d) vel=(%0d,%0d) mov=%b sunk=%b rdy=%b, want pos=(%0d,%0d) vel=(%0d,%0d) mov=%b sunk=%b rdy=%b",
                     name, topLeftX, topLeftY, velX, velY, moving, sunk, hitReady,
                     ex, ey, evx, evy, emov, esunk, erdy);
        end
    endtask

    initial begin
        bit reached;
        resetN = 1'b1; startOfFrame = 1'b0; collisionOccurred = 1'b0;
        velXIn = '0; velYIn = '0; hitValid = 1'b0; hitVelX = '0; hitVelY = '0;
        holeDR = 1'b0; respawn = 1'b0;

        //           rst  sof  col  vxi vyi hit hvx hvy   x    y   vx  vy  mov rdy
        vecs.push_back(mk(1, 0, 0,   0,  0, 0,  0,  0, 100, 200,   0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0,   0,  0, 0,  0,  0, 100, 200,   0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   0,  0, 0,  0,  0, 100, 200,   0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,   0,  0, 1, 32,  0, 100, 200,   0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0,   0,  0, 0,  0,  0, 101, 200,  31, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,   0,  0, 0,  0,  0, 101, 200,  31, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0,   0,  0, 0,  0,  0, 103, 200,  30, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0,   0,  0, 0,  0,  0, 105, 200,  29, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, -20,  5, 0,  0,  0, 105, 200,  29, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0,   0,  0, 0,  0,  0, 104, 200, -19, 4, 1, 0));
        vecs.push_back(mk(0, 0, 0,   0,  0, 1, 50, 50, 104, 200, -19, 4, 1, 0));
        vecs.push_back(mk(0, 1, 0,   0,  0, 0,  0,  0, 103, 200, -18, 3, 1, 0));
        vecs.push_back(mk(0, 1, 1,   1, -1, 0,  0,  0, 103, 200,   0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1,   3,  0, 0,  0,  0, 103, 200,   0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0,   0,  0, 0,  0,  0, 103, 200,   2, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0,   0,  0, 0,  0,  0, 103, 200,   1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0,   0,  0, 0,  0,  0, 103, 200,   0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, -40,  0, 1, 32, 32, 103, 200,   0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0,   0,  0, 0,  0,  0, 101, 200, -39, 0, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].sof, vecs[i].col, vecs[i].vxi, vecs[i].vyi,
                          vecs[i].hit, vecs[i].hvx, vecs[i].hvy, vecs[i].hole, vecs[i].resp);
            checkOutput($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].evx,
                        vecs[i].evy, vecs[i].emov, vecs[i].esunk, vecs[i].erdy);
        end

        // Hole coincident with a tick wins; strikes and ticks are ignored while sunk.
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("hole_tick", 101, 200, 0, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 1, 32, 0, 0, 0);
        checkOutput("sunk_hit_ignored", 101, 200, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("respawn", 100, 200, 0, 0, 0, 0, 1);

        // Oversized strike saturates, then the ball runs into the right wall.
        applyStimulus(0, 0, 0, 0, 0, 1, 400, 0, 0, 0);
        checkOutput("big_strike", 100, 200, 0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("saturate", 115, 200, 254, 0, 1, 0, 0);
        reached = 1'b0;
        for (int t = 0; t < 60 && !reached; t++) begin
            applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            if (topLeftX == 11'sd608) reached = 1'b1;
        end
        checkOutput("clamp_max_x", 608, 200, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("clamp_hold", 608, 200, 0, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
